lsu_data_mem: RTL and testbench
===============================

Name: lsu_data_mem

Overview:
Parametrised data memory with load/store unit, successor to the single-cycle word-only data memory. Supports RV32 byte, halfword and word loads and stores, with sign or zero extension. Adds a valid/ready request handshake, configurable wait-state latency, and misalignment and range error reporting. Sits between the datapath (ALU result = address, rs2 = write data, funct3 = size) and the processor stall logic.

Parameters:
XLEN, 32, data and address width
DEPTH_BYTES, 256, memory size in bytes; power of two, >= 4
WAIT_CYCLES, 1, extra cycles between accept and response; 0 to 15

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  access size/sign (RV32 funct3 encoding)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data; low bytes are used for SB/SH
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  qualified by rsp_valid: misaligned, out-of-range or illegal funct3
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
- Reset does not clear memory. At time 0, mem[i] = i[7:0] for simulation.
- Memory is little-endian: the byte at addr is bits [7:0].
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid && req_ready. On accept, latch we, funct3, addr and wdata, and run the checks.
  - Check fail -> RESP with err=1; memory is not touched.
  - Check pass -> WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to RESP when it reaches 0.
- Transition into RESP:
  - The access is performed on that clock edge.
  - Store: byte-enable write.
  - Load: read, extract and extend, then register into rsp_rdata.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0, next state IDLE.
  - Request to rsp_valid latency = WAIT_CYCLES+1 cycles.
  - Maximum throughput = one request per WAIT_CYCLES+2 cycles.
- Legal funct3 values:
  - Loads: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is an error.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Violation is an error.
- Range: addr + size - 1 must be < DEPTH_BYTES, with the full XLEN address compared, no wrap. Out of range is an error.
- Store writes only the size-selected bytes; other bytes are unchanged.
- rsp_rdata and rsp_err hold their values after rsp_valid drops, until the next response.
- req_valid outside IDLE is ignored. The requester must hold it until req_ready.
- Reset asserted mid-operation (WAIT or RESP): return to the reset state; no response is issued. A store still in WAIT never commits. A store whose commit edge coincides with rst is also not committed: rst has priority.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Helpers: size_bytes(funct3), is_legal(we, funct3).
- One combinational sub-module, lsu_byte_lane:
  - Inputs: funct3, addr[1:0], wdata, raw word.
  - Outputs: 4-bit byte enable, lane-shifted write data, extended load data.
- Top level holds the FSM, wait counter, byte-array storage and checks.

Test Plan:
- WAIT_CYCLES=1, reset, then LW addr 0x4 -> rsp_valid exactly 2 cycles after accept; rsp_rdata=0x07060504, rsp_err=0; req_ready low for 2 cycles.
- LB addr 0x80 -> 0xFFFFFF80. LBU addr 0x80 -> 0x00000080. LHU addr 0x82 -> 0x00008382. LH addr 0xFE -> 0xFFFFFFFE.
- SH addr 0x2, wdata 0x1234ABCD, then LW addr 0x0 -> 0xABCD0100. Then SB addr 0x1, wdata 0xEE, then LW addr 0x0 -> 0xABCDEE00.
- LW addr 0x6 -> rsp_err=1, rsp_rdata=0. SW addr 0xFE -> err. LW addr 0xFC -> 0xFFFEFDFC with no err. LW addr 0x100 -> err. funct3=011 -> err. Memory unchanged after each error case.
- WAIT_CYCLES=3: SW addr 0x10, wdata 0xDEADBEEF, rst pulsed in the 2nd WAIT cycle -> no rsp_valid, req_ready=1 the cycle after rst. A following LW addr 0x10 -> 0x13121110.
- WAIT_CYCLES=0: back-to-back requests with req_valid held high -> accepts every 2 cycles. Each rsp_valid is a 1-cycle pulse, and responses come back in request order.

Source files
------------

// File: rtl/lsu_data_mem_pkg.sv
// Shared definitions for the load/store data memory: RV32 funct3 codes,
// FSM state encoding and request-decoding helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic illegal;
    logic misaligned;
    logic out_of_range;
  } chk_t;

  // Illegal codes report 4 so the range check stays conservative.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response bus between the datapath and the load/store data memory.
interface lsu_data_mem_if #(
  parameter int XLEN = 32
);
  // Handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both high; the requester holds req_valid and its payload
  // stable until then. rsp_valid is a single-cycle pulse with no back-pressure;
  // rsp_rdata/rsp_err stay stable until the next response.
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, dbg_state
  );

endinterface

// File: rtl/lsu_data_mem_byte_lane.sv
// Byte-lane steering for one RV32 word: store byte enables and replicated
// write data, plus load extraction with sign/zero extension.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = raw_word >> {addr_lo, 3'b000};
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        // Replicating the low byte lets byte_en alone pick the target lane.
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0, shifted[15:0]};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = raw_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_data_mem.sv
// Byte-addressed data memory with an RV32 load/store front end, a
// valid/ready request port, programmable wait states and error reporting.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  lsu_data_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int MW = AW + 3;

  function automatic logic [8*DEPTH_BYTES-1:0] mem_init();
    logic [8*DEPTH_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < DEPTH_BYTES; i++) m[8*i +: 8] = 8'(i);
    return m;
  endfunction

  // Byte i lives at bits [8i+7:8i]; the power-up image is mem[i] = i.
  logic [8*DEPTH_BYTES-1:0] mem_q = mem_init();
  logic [8*DEPTH_BYTES-1:0] mem_d;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            cur_we;
  logic [2:0]      cur_f3;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [2:0]      cur_size;
  logic [XLEN:0]   end_addr;
  chk_t            chk;
  logic [AW-1:0]   word_base;
  logic [MW-1:0]   word_lsb;
  logic [31:0]     raw_word;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lane;
  logic [31:0]     rdata_ext;
  logic            accept;
  logic            commit;

  // In IDLE the live request is decoded so a zero-wait access can commit on
  // its accept edge; afterwards the latched copy is used.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_f3    = bus.req_funct3;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = we_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    cur_size         = size_bytes(cur_f3);
    end_addr         = {1'b0, cur_addr} + (XLEN+1)'(cur_size) - (XLEN+1)'(1);
    chk.illegal      = !is_legal(cur_we, cur_f3);
    chk.misaligned   = ((cur_size == 3'd2) && cur_addr[0]) ||
                       ((cur_size == 3'd4) && (cur_addr[1:0] != 2'b00));
    chk.out_of_range = end_addr >= (XLEN+1)'(DEPTH_BYTES);
    word_base        = cur_addr[AW-1:0] & ~AW'(3);
    word_lsb         = {word_base, 3'b000};
    raw_word         = mem_q[word_lsb +: 32];
  end

  lsu_byte_lane u_lane (
    .funct3     (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (|chk) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = cur_we ? '0 : XLEN'(rdata_ext);
    end
  end

  // rst overrides a commit landing on the same edge.
  always_comb begin
    mem_d = mem_q;
    if (commit && cur_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_d[{word_base + AW'(b), 3'b000} +: 8] = wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: three instances (1, 3 and 0 wait states) checked
// against a byte-array reference model and directed expectations.
module tb_lsu_data_mem;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [2:0]  vld;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rdy, rv, er, bsy;
  logic [31:0] rd [3];
  logic [1:0]  st [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [3][256];

  // instance 0: 1 wait state, 1: 3 wait states, 2: no wait states
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    lsu_data_mem_if #(.XLEN(32)) bus ();
    assign bus.req_valid  = vld[g];
    assign bus.req_we     = we;
    assign bus.req_funct3 = f3;
    assign bus.req_addr   = addr;
    assign bus.req_wdata  = wdata;
    assign rdy[g] = bus.req_ready;
    assign rv[g]  = bus.rsp_valid;
    assign er[g]  = bus.rsp_err;
    assign bsy[g] = bus.busy;
    assign rd[g]  = bus.rsp_rdata;
    assign st[g]  = bus.dbg_state;
    lsu_data_mem #(.XLEN(32), .DEPTH_BYTES(256), .WAIT_CYCLES(WC)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_req(input int d, input logic m_we, input logic [2:0] m_f3,
                           input logic [31:0] m_addr, input logic [31:0] m_wdata,
                           output logic m_err, output logic [31:0] m_rdata);
    int sz;
    bit sgn;
    logic [31:0] v;
    sz = 0;
    sgn = 0;
    case (m_f3)
      3'b000: begin sz = 1; sgn = 1; end
      3'b001: begin sz = 2; sgn = 1; end
      3'b010: sz = 4;
      3'b100: sz = 1;
      3'b101: sz = 2;
      default: sz = 0;
    endcase
    m_err = (sz == 0) || (m_we && m_f3[2]);
    if (!m_err) begin
      if ((m_addr % sz) != 0) m_err = 1'b1;
      if (longint'(m_addr) + longint'(sz) > 256) m_err = 1'b1;
    end
    m_rdata = 32'h0;
    if (!m_err) begin
      if (m_we) begin
        for (int i = 0; i < sz; i++) mm[d][m_addr + i] = 8'(m_wdata >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mm[d][m_addr + i]) << (8 * i));
        if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        m_rdata = v;
      end
    end
  endtask

  task automatic gen_req(output logic g_we, output logic [2:0] g_f3,
                         output logic [31:0] g_addr, output logic [31:0] g_wdata);
    int r;
    int sz;
    logic [2:0] ld_codes [5];
    ld_codes = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    g_we = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    if (r < 8) g_f3 = g_we ? ld_codes[$urandom_range(0, 2)] : ld_codes[$urandom_range(0, 4)];
    else       g_f3 = 3'($urandom_range(0, 7));
    sz = (g_f3[1:0] == 2'b00) ? 1 : ((g_f3[1:0] == 2'b01) ? 2 : 4);
    g_addr = 32'($urandom_range(0, 255));
    r = $urandom_range(0, 9);
    if (r < 7)       g_addr = g_addr & ~32'(sz - 1);
    else if (r == 7) g_addr = 32'($urandom_range(250, 260));
    else if (r == 8) g_addr = $urandom;
    g_wdata = $urandom;
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input int d, input logic r_we, input logic [2:0] r_f3,
                           input logic [31:0] r_addr, input logic [31:0] r_wdata,
                           output logic [31:0] o_rdata, output logic o_err,
                           output int o_lat, output logic o_hs);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    we = r_we; f3 = r_f3; addr = r_addr; wdata = r_wdata;
    vld[d] = 1'b1;
    @(negedge clk);
    vld[d] = 1'b0;
    o_lat = 1;
    o_hs = 1'b1;
    while (!rv[d] && o_lat < 40) begin
      if (rdy[d]) o_hs = 1'b0;
      @(negedge clk);
      o_lat++;
    end
    if (rdy[d] || !bsy[d]) o_hs = 1'b0;
    o_rdata = rd[d];
    o_err = er[d];
    @(negedge clk);
    if (rv[d] || !rdy[d] || bsy[d] || rd[d] !== o_rdata || er[d] !== o_err) o_hs = 1'b0;
  endtask

  task automatic reset_during(input int d, input logic r_we, input logic [2:0] r_f3,
                              input logic [31:0] r_addr, input logic [31:0] r_wdata,
                              input int k, output logic saw_rsp, output logic rdy_after);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    we = r_we; f3 = r_f3; addr = r_addr; wdata = r_wdata;
    vld[d] = 1'b1;
    @(negedge clk);
    vld[d] = 1'b0;
    saw_rsp = 1'b0;
    for (int i = 1; i < k; i++) begin
      if (rv[d]) saw_rsp = 1'b1;
      @(negedge clk);
    end
    if (rv[d]) saw_rsp = 1'b1;
    rst_v[d] = 1'b1;
    @(negedge clk);
    rst_v[d] = 1'b0;
    rdy_after = rdy[d];
    if (rv[d]) saw_rsp = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rv[d]) saw_rsp = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_v = 3'b111;
    vld = 3'b000;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rdy[d], rv[d], er[d], bsy[d], rd[d], st[d]} !== {4'b1000, 32'h0, IDLE}) begin
        errors++;
        $display("FAIL reset[%0d] got ready=%b valid=%b err=%b busy=%b rdata=%h state=%0d want 1 0 0 0 00000000 0",
                 d, rdy[d], rv[d], er[d], bsy[d], rd[d], st[d]);
      end
    end
    rst_v = 3'b000;
  endtask

  task automatic test_load_latency();
    logic [31:0] rdata, mr;
    logic err, hs, me;
    int lat;
    model_req(0, 1'b0, F3_W, 32'h4, 32'h0, me, mr);
    drive_req(0, 1'b0, F3_W, 32'h4, 32'h0, rdata, err, lat, hs);
    checks++;
    if ({err, rdata} !== {1'b0, 32'h0706_0504}) begin
      errors++;
      $display("FAIL lw_0x4 got err=%b rdata=%h want err=0 rdata=07060504", err, rdata);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL lw_latency got %0d want 2", lat);
    end
    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("FAIL lw_handshake got ready/pulse shape bad want ready low 2 cycles and 1-cycle rsp_valid");
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  t_f3 [4];
    logic [31:0] t_addr [4];
    logic [31:0] t_exp [4];
    logic [31:0] rdata, mr;
    logic err, hs, me;
    int lat;
    t_f3   = '{F3_B, F3_BU, F3_HU, F3_H};
    t_addr = '{32'h80, 32'h80, 32'h82, 32'hFE};
    t_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8382, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      model_req(0, 1'b0, t_f3[i], t_addr[i], 32'h0, me, mr);
      drive_req(0, 1'b0, t_f3[i], t_addr[i], 32'h0, rdata, err, lat, hs);
      checks++;
      if ({err, rdata} !== {1'b0, t_exp[i]} || lat != 2 || hs !== 1'b1) begin
        errors++;
        $display("FAIL load_ext[%0d] f3=%0d addr=%h got err=%b rdata=%h lat=%0d hs=%b want err=0 rdata=%h lat=2 hs=1",
                 i, t_f3[i], t_addr[i], err, rdata, lat, hs, t_exp[i]);
      end
    end
  endtask

  task automatic test_store_merge();
    logic        t_we [4];
    logic [2:0]  t_f3 [4];
    logic [31:0] t_addr [4];
    logic [31:0] t_wd [4];
    logic [31:0] t_exp [4];
    logic [31:0] rdata, mr;
    logic err, hs, me;
    int lat;
    t_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_f3   = '{F3_H, F3_W, F3_B, F3_W};
    t_addr = '{32'h2, 32'h0, 32'h1, 32'h0};
    t_wd   = '{32'h1234_ABCD, 32'h0, 32'h0000_00EE, 32'h0};
    t_exp  = '{32'h0, 32'hABCD_0100, 32'h0, 32'hABCD_EE00};
    for (int i = 0; i < 4; i++) begin
      model_req(0, t_we[i], t_f3[i], t_addr[i], t_wd[i], me, mr);
      drive_req(0, t_we[i], t_f3[i], t_addr[i], t_wd[i], rdata, err, lat, hs);
      checks++;
      if ({err, rdata} !== {1'b0, t_exp[i]} || lat != 2 || hs !== 1'b1) begin
        errors++;
        $display("FAIL store_merge[%0d] got err=%b rdata=%h lat=%0d hs=%b want err=0 rdata=%h lat=2 hs=1",
                 i, err, rdata, lat, hs, t_exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        t_we [11];
    logic [2:0]  t_f3 [11];
    logic [31:0] t_addr [11];
    logic        t_err [11];
    logic [31:0] t_exp [11];
    logic [31:0] rdata, mr;
    logic err, hs, me;
    int lat;
    t_we   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_f3   = '{F3_W, F3_W, F3_W, F3_W, 3'b011, F3_W, 3'b011, F3_B, F3_W, F3_W, F3_W};
    t_addr = '{32'h6, 32'hFE, 32'hFC, 32'h100, 32'h8, 32'h6, 32'h8, 32'h8000_0010,
               32'h4, 32'h8, 32'hFC};
    t_err  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t_exp  = '{32'h0, 32'h0, 32'hFFFE_FDFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h0706_0504, 32'h0B0A_0908, 32'hFFFE_FDFC};
    for (int i = 0; i < 11; i++) begin
      model_req(0, t_we[i], t_f3[i], t_addr[i], 32'h5A5A_5A5A, me, mr);
      drive_req(0, t_we[i], t_f3[i], t_addr[i], 32'h5A5A_5A5A, rdata, err, lat, hs);
      checks++;
      if ({err, rdata} !== {t_err[i], t_exp[i]} || lat != (t_err[i] ? 1 : 2) || hs !== 1'b1) begin
        errors++;
        $display("FAIL errors[%0d] addr=%h got err=%b rdata=%h lat=%0d hs=%b want err=%b rdata=%h lat=%0d hs=1",
                 i, t_addr[i], err, rdata, lat, hs, t_err[i], t_exp[i], t_err[i] ? 1 : 2);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic saw, rdy_after, err, hs;
    logic [31:0] rdata;
    int lat;
    reset_during(1, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 2, saw, rdy_after);
    checks++;
    if (saw !== 1'b0 || rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait got rsp_seen=%b ready_after=%b want 0 1", saw, rdy_after);
    end
    drive_req(1, 1'b0, F3_W, 32'h10, 32'h0, rdata, err, lat, hs);
    checks++;
    if ({err, rdata} !== {1'b0, 32'h1312_1110} || lat != 4 || hs !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait_load got err=%b rdata=%h lat=%0d want err=0 rdata=13121110 lat=4",
               err, rdata, lat);
    end
  endtask

  task automatic test_reset_on_commit();
    logic saw, rdy_after, err, hs;
    logic [31:0] rdata;
    int lat;
    reset_during(1, 1'b1, F3_W, 32'h20, 32'hA5A5_A5A5, 3, saw, rdy_after);
    checks++;
    if (saw !== 1'b0 || rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL reset_on_commit got rsp_seen=%b ready_after=%b want 0 1", saw, rdy_after);
    end
    drive_req(1, 1'b0, F3_W, 32'h20, 32'h0, rdata, err, lat, hs);
    checks++;
    if ({err, rdata} !== {1'b0, 32'h2322_2120}) begin
      errors++;
      $display("FAIL reset_on_commit_load got err=%b rdata=%h want err=0 rdata=23222120", err, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic g_we, me;
    logic [2:0] g_f3;
    logic [31:0] g_addr, g_wd, mr;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      gen_req(g_we, g_f3, g_addr, g_wd);
      model_req(2, g_we, g_f3, g_addr, g_wd, me, mr);
      checks++;
      if (rdy[2] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got ready=%b want 1", k, rdy[2]);
      end
      we = g_we; f3 = g_f3; addr = g_addr; wdata = g_wd;
      vld[2] = 1'b1;
      @(negedge clk);
      checks++;
      if ({rv[2], rdy[2], er[2], rd[2]} !== {2'b10, me, mr}) begin
        errors++;
        $display("FAIL b2b_rsp[%0d] got valid=%b ready=%b err=%b rdata=%h want 1 0 %b %h",
                 k, rv[2], rdy[2], er[2], rd[2], me, mr);
      end
      @(negedge clk);
      checks++;
      if ({rv[2], rdy[2]} !== 2'b01) begin
        errors++;
        $display("FAIL b2b_pulse[%0d] got valid=%b ready=%b want 0 1", k, rv[2], rdy[2]);
      end
    end
    vld[2] = 1'b0;
  endtask

  task automatic test_random(input int d, input int count);
    logic g_we, me, err, hs;
    logic [2:0] g_f3;
    logic [31:0] g_addr, g_wd, mr, rdata;
    int lat;
    for (int k = 0; k < count; k++) begin
      gen_req(g_we, g_f3, g_addr, g_wd);
      model_req(d, g_we, g_f3, g_addr, g_wd, me, mr);
      drive_req(d, g_we, g_f3, g_addr, g_wd, rdata, err, lat, hs);
      checks++;
      if ({err, rdata} !== {me, mr} || lat != (me ? 1 : wc_of(d) + 1) || hs !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d.%0d] we=%b f3=%0d addr=%h got err=%b rdata=%h lat=%0d hs=%b want err=%b rdata=%h lat=%0d hs=1",
                 d, k, g_we, g_f3, g_addr, err, rdata, lat, hs, me, mr, me ? 1 : wc_of(d) + 1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) mm[d][i] = 8'(i);
    vld = 3'b000;
    we = 1'b0;
    f3 = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    test_reset();
    test_load_latency();
    test_load_ext();
    test_store_merge();
    test_errors();
    test_reset_mid_wait();
    test_reset_on_commit();
    test_back_to_back();
    test_random(0, 40);
    test_random(1, 25);
    test_random(2, 25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
